// File: rtl/bios_watchdog_gen2_pkg.sv
// Shared definitions for the BIOS boot watchdog: FSM state encoding (also
// the WdState readback value), BIOS command codes and TimeoutCause encoding.
package bios_wd_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_KPAUSE  = 3'd1,
        ST_HOLD    = 3'd2,
        ST_DONE    = 3'd3,
        ST_EXPIRED = 3'd4
    } wd_state_t;

    localparam logic [7:0] CMD_DONE      = 8'hFF;
    localparam logic [7:0] CMD_KPAUSE    = 8'h55;
    localparam logic [7:0] CMD_HOLD      = 8'h29;
    localparam logic [7:0] CMD_RESUME    = 8'hAA;
    localparam logic [3:0] CMD_LIMIT_PFX = 4'hC;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_KICK  = 2'b01;
    localparam logic [1:0] CAUSE_TOTAL = 2'b10;
    localparam logic [1:0] CAUSE_BOTH  = 2'b11;

    // 0xC0..0xCF reprograms the kick limit
    function automatic logic is_limit_cmd(input logic [7:0] v);
        return v[7:4] == CMD_LIMIT_PFX;
    endfunction

endpackage

// File: rtl/bios_watchdog_gen2_if.sv
// Register-decoder side bundle of the BIOS watchdog.
//   master: drives Strobe, WriteBiosWD, BiosRegister, BootAttempt
//   slave : drives BiosFinished, ForceSwap, BiosPowerOff, WdTimeout,
//           TimeoutCause, WdState
interface bios_watchdog_gen2_if
    import bios_wd_pkg::*;
#(
    parameter int RETRY_W = 2
);
    logic               Strobe;
    logic               WriteBiosWD;
    logic [7:0]         BiosRegister;
    logic [RETRY_W-1:0] BootAttempt;
    logic               BiosFinished;
    logic               ForceSwap;
    logic               BiosPowerOff;
    logic               WdTimeout;
    logic [1:0]         TimeoutCause;
    wd_state_t          WdState;

    modport master (
        output Strobe, WriteBiosWD, BiosRegister, BootAttempt,
        input  BiosFinished, ForceSwap, BiosPowerOff, WdTimeout, TimeoutCause, WdState
    );

    modport slave (
        input  Strobe, WriteBiosWD, BiosRegister, BootAttempt,
        output BiosFinished, ForceSwap, BiosPowerOff, WdTimeout, TimeoutCause, WdState
    );
endinterface

// File: rtl/bios_watchdog_gen2_counter.sv
// Saturating tick counter with a reached-limit flag.
//   clk, rst_n : clock, async active-low reset
//   clr        : force count to 0 (highest priority)
//   hold       : freeze count
//   en         : count one tick
//   limit      : compare value
//   hit        : the value being registered this cycle is >= limit, so the
//                owner can react on the same edge the limit is reached
module bios_wd_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         hold,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         hit
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (!hold && en && cnt_q != {W{1'b1}})
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign hit = (cnt_d >= limit);
endmodule

// File: rtl/bios_watchdog_gen2.sv
// BIOS POST watchdog: kick (heartbeat) timer plus overall boot timer.
// Expiry requests a flash bank swap, or power-off once BootAttempt has
// reached MAX_RETRY.
//   LpcClock  : LPC clock
//   MainReset : async active-low reset
//   bus       : slave side of bios_watchdog_gen2_if (strobe/write/data/
//               attempt in; finished/swap/poweroff/timeout/cause/state out)
module bios_watchdog_gen2
    import bios_wd_pkg::*;
#(
    parameter int TOTAL_W        = 10,
    parameter int TOTAL_LIMIT    = 512,
    parameter int KICK_W         = 6,
    parameter int KICK_LIMIT_DEF = 32,
    parameter int RETRY_W        = 2,
    parameter int MAX_RETRY      = 2
) (
    input  logic LpcClock,
    input  logic MainReset,
    bios_watchdog_gen2_if.slave bus
);
    wd_state_t         state_q, state_d;
    logic [KICK_W-1:0] kick_limit_q, kick_limit_new;
    logic [KICK_W:0]   lim_wide;
    logic [RETRY_W-1:0] attempt;
    logic live, wr, cmd_done, kick_hit, tot_hit, expire, retry_left;
    logic finished_q, swap_q, poff_q, timeout_q;
    logic [1:0] cause_q;

    // Writes are ignored once DONE or EXPIRED
    assign wr         = bus.WriteBiosWD && (state_q inside {ST_RUN, ST_KPAUSE, ST_HOLD});
    assign live       = state_q inside {ST_RUN, ST_KPAUSE};
    assign cmd_done   = wr && (bus.BiosRegister == CMD_DONE);
    assign attempt    = bus.BootAttempt;
    assign retry_left = int'(attempt) < MAX_RETRY;

    // (val+1) * 2^(KICK_W-4) - 1, computed one bit wider to hold 2^KICK_W
    assign lim_wide       = ((KICK_W+1)'(bus.BiosRegister[3:0]) + 1'b1) << (KICK_W - 4);
    assign kick_limit_new = KICK_W'(lim_wide - 1'b1);

    // Any accepted write is a kick; clearing wins over a same-cycle Strobe.
    // KPAUSE pins the kick counter at 0.
    bios_wd_counter #(.W(KICK_W)) u_kick (
        .clk   (LpcClock),
        .rst_n (MainReset),
        .clr   (wr || state_q == ST_KPAUSE),
        .hold  (state_q == ST_HOLD),
        .en    (bus.Strobe && state_q == ST_RUN),
        .limit (kick_limit_q),
        .hit   (kick_hit)
    );

    bios_wd_counter #(.W(TOTAL_W)) u_total (
        .clk   (LpcClock),
        .rst_n (MainReset),
        .clr   (1'b0),
        .hold  (state_q == ST_HOLD),
        .en    (bus.Strobe && live),
        .limit (TOTAL_W'(TOTAL_LIMIT)),
        .hit   (tot_hit)
    );

    always_ff @(posedge LpcClock or negedge MainReset) begin
        if (!MainReset) state_q <= ST_RUN;
        else            state_q <= state_d;
    end

    // Expiry overrides every command except DONE
    always_comb begin
        state_d = state_q;
        expire  = 1'b0;
        if (wr) begin
            case (bus.BiosRegister)
                CMD_DONE:   state_d = ST_DONE;
                CMD_KPAUSE: state_d = ST_KPAUSE;
                CMD_HOLD:   state_d = ST_HOLD;
                CMD_RESUME: state_d = ST_RUN;
                default:    ;
            endcase
        end
        if (live && (kick_hit || tot_hit) && !cmd_done) begin
            state_d = ST_EXPIRED;
            expire  = 1'b1;
        end
    end

    always_ff @(posedge LpcClock or negedge MainReset) begin
        if (!MainReset) begin
            kick_limit_q <= KICK_W'(KICK_LIMIT_DEF);
            finished_q   <= 1'b0;
            swap_q       <= 1'b0;
            poff_q       <= 1'b0;
            timeout_q    <= 1'b0;
            cause_q      <= CAUSE_NONE;
        end else begin
            if (wr && is_limit_cmd(bus.BiosRegister))
                kick_limit_q <= kick_limit_new;
            swap_q <= expire && retry_left;
            if (state_d == ST_DONE)
                finished_q <= 1'b1;
            if (expire) begin
                timeout_q <= 1'b1;
                cause_q   <= tot_hit ? (kick_hit ? CAUSE_BOTH : CAUSE_TOTAL) : CAUSE_KICK;
                if (!retry_left)
                    poff_q <= 1'b1;
            end
        end
    end

    assign bus.WdState      = state_q;
    assign bus.BiosFinished = finished_q;
    assign bus.ForceSwap    = swap_q;
    assign bus.BiosPowerOff = poff_q;
    assign bus.WdTimeout    = timeout_q;
    assign bus.TimeoutCause = cause_q;
endmodule
